// File: rtl/dvs_ravens_pkg.sv
// Shared DVS constants, the default-width packed event record and width helpers.
package dvs_ravens_pkg;

   // Sensor geometry and timing of the original fixed-format design
   localparam int DVS_WIDTH_PXLS    = 346;
   localparam int DVS_HEIGHT_PXLS   = 260;
   localparam int DVS_CLK_DIV       = 1000;
   localparam int DVS_TS_BITS       = 48;
   localparam int DVS_FIFO_DEPTH    = 4;
   localparam int DVS_DROP_CNT_BITS = 16;

   localparam int DVS_X_BITS = $clog2(DVS_WIDTH_PXLS);
   localparam int DVS_Y_BITS = $clog2(DVS_HEIGHT_PXLS);

   // Packed event at default widths; x sits in the MSBs
   typedef struct packed {
      logic [DVS_X_BITS-1:0]  x;
      logic [DVS_Y_BITS-1:0]  y;
      logic                   pol;
      logic [DVS_TS_BITS-1:0] ts_us;
   } dvs_event_t;

   // Total packed event width for arbitrary field widths
   function automatic int dvs_event_bits(input int x_bits, input int y_bits, input int ts_bits);
      return x_bits + y_bits + 1 + ts_bits;
   endfunction

   // Prescaler width: never less than one bit, even for a divisor of 1
   function automatic int dvs_pre_bits(input int divisor);
      return (divisor <= 2) ? 1 : $clog2(divisor);
   endfunction

endpackage

// File: rtl/dvs_event_fifo.sv
// Small synchronous FIFO with registered storage and full/empty flags.
// DEPTH must be a power of two so the pointers wrap on their own.
module dvs_event_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CNT_FULL);
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Head reads as zero when nothing is buffered so the output is clean after reset
   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

   // Next pointer and occupancy values
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage write; contents need no reset because occupancy gates the head
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/dvs_event_packer.sv
// Timestamps DVS pixel events, range-checks coordinates, counts drops and
// buffers packed events {x, y, pol, ts_us} for a valid/ready consumer.
// Handshakes: a transfer happens on any rising edge where valid && ready;
// the producer holds its data while valid && !ready.
module dvs_event_packer
   import dvs_ravens_pkg::*;
#(
   parameter  int WIDTH_PXLS            = DVS_WIDTH_PXLS,
   parameter  int HEIGHT_PXLS           = DVS_HEIGHT_PXLS,
   parameter  int CLK_PERIOD_US_DIVISOR = DVS_CLK_DIV,
   parameter  int TIMESTAMP_US_BITS     = DVS_TS_BITS,
   parameter  int FIFO_DEPTH            = DVS_FIFO_DEPTH,
   parameter  int DROP_CNT_BITS         = DVS_DROP_CNT_BITS,
   localparam int X_BITS                = $clog2(WIDTH_PXLS),
   localparam int Y_BITS                = $clog2(HEIGHT_PXLS),
   localparam int EVENT_BITS            = dvs_event_bits(X_BITS, Y_BITS, TIMESTAMP_US_BITS),
   localparam int PRE_BITS              = dvs_pre_bits(CLK_PERIOD_US_DIVISOR)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         ts_clear,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [X_BITS-1:0]            in_x,
   input  logic [Y_BITS-1:0]            in_y,
   input  logic                         in_pol,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [EVENT_BITS-1:0]        out_event,
   output logic [TIMESTAMP_US_BITS-1:0] ts_us,
   output logic                         ts_wrap,
   output logic [DROP_CNT_BITS-1:0]     drop_count
);

   localparam logic [PRE_BITS-1:0] PRE_LAST = PRE_BITS'(CLK_PERIOD_US_DIVISOR - 1);
   localparam logic [X_BITS:0]     X_LIMIT  = (X_BITS+1)'(WIDTH_PXLS);
   localparam logic [Y_BITS:0]     Y_LIMIT  = (Y_BITS+1)'(HEIGHT_PXLS);

   logic [PRE_BITS-1:0]          pre_q, pre_d;
   logic [TIMESTAMP_US_BITS-1:0] ts_q, ts_d;
   logic                         wrap_q, wrap_d;
   logic [DROP_CNT_BITS-1:0]     drop_q, drop_d;

   logic                  tick;
   logic                  accept;
   logic                  in_range;
   logic                  fifo_full, fifo_empty;
   logic [EVENT_BITS-1:0] packed_event;

   assign tick     = (pre_q == PRE_LAST);
   assign in_range = ({1'b0, in_x} < X_LIMIT) && ({1'b0, in_y} < Y_LIMIT);

   // No pass-through: a full buffer refuses input even if the consumer pops this cycle
   assign in_ready = !fifo_full && !rst;
   assign accept   = in_valid && in_ready;

   // Stamp with the timestamp as registered, before this cycle's tick or clear
   assign packed_event = {in_x, in_y, in_pol, ts_q};

   assign out_valid  = !fifo_empty;
   assign ts_us      = ts_q;
   assign ts_wrap    = wrap_q;
   assign drop_count = drop_q;

   // Prescaler, timestamp and wrap pulse; clear wins over the increment
   always_comb begin
      pre_d  = tick ? '0 : pre_q + PRE_BITS'(1);
      ts_d   = ts_q;
      wrap_d = 1'b0;
      if (ts_clear) begin
         pre_d = '0;
         ts_d  = '0;
      end else if (tick) begin
         ts_d   = ts_q + TIMESTAMP_US_BITS'(1);
         wrap_d = (ts_q == '1);
      end
   end

   // Saturating count of accepted events whose coordinates are off-sensor
   always_comb begin
      drop_d = drop_q;
      if (accept && !in_range && (drop_q != '1)) drop_d = drop_q + DROP_CNT_BITS'(1);
   end

   // Timing and drop-count registers
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q  <= '0;
         ts_q   <= '0;
         wrap_q <= 1'b0;
         drop_q <= '0;
      end else begin
         pre_q  <= pre_d;
         ts_q   <= ts_d;
         wrap_q <= wrap_d;
         drop_q <= drop_d;
      end
   end

   dvs_event_fifo #(
      .WIDTH (EVENT_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (accept && in_range),
      .wdata_i (packed_event),
      .pop_i   (out_ready),
      .rdata_o (out_event),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

endmodule

// File: tb/tb_dvs_event_packer.sv
// Bench for dvs_event_packer: one main instance (divisor 1, 8-bit timestamp)
// plus two timing-only instances (divisor 4; 4-bit timestamp wrap).
module tb_dvs_event_packer;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- main instance ----------------
   logic        ts_clear_a, in_valid_a, out_ready_a, in_pol_a;
   logic [8:0]  in_x_a, in_y_a;
   logic        in_ready_a, out_valid_a, ts_wrap_a;
   logic [26:0] out_event_a;
   logic [7:0]  ts_a;
   logic [15:0] drop_a;

   dvs_event_packer #(
      .CLK_PERIOD_US_DIVISOR (1),
      .TIMESTAMP_US_BITS     (8)
   ) u_a (
      .clk (clk), .rst (rst), .ts_clear (ts_clear_a),
      .in_valid (in_valid_a), .in_ready (in_ready_a),
      .in_x (in_x_a), .in_y (in_y_a), .in_pol (in_pol_a),
      .out_valid (out_valid_a), .out_ready (out_ready_a), .out_event (out_event_a),
      .ts_us (ts_a), .ts_wrap (ts_wrap_a), .drop_count (drop_a)
   );

   // ---------------- timing-only instances ----------------
   logic        in_ready_b, out_valid_b, ts_wrap_b;
   logic [66:0] out_event_b;
   logic [47:0] ts_b;
   logic [15:0] drop_b;

   dvs_event_packer #(
      .CLK_PERIOD_US_DIVISOR (4)
   ) u_b (
      .clk (clk), .rst (rst), .ts_clear (1'b0),
      .in_valid (1'b0), .in_ready (in_ready_b),
      .in_x (9'd0), .in_y (9'd0), .in_pol (1'b0),
      .out_valid (out_valid_b), .out_ready (1'b0), .out_event (out_event_b),
      .ts_us (ts_b), .ts_wrap (ts_wrap_b), .drop_count (drop_b)
   );

   logic        in_ready_c, out_valid_c, ts_wrap_c;
   logic [22:0] out_event_c;
   logic [3:0]  ts_c;
   logic [15:0] drop_c;

   dvs_event_packer #(
      .CLK_PERIOD_US_DIVISOR (1),
      .TIMESTAMP_US_BITS     (4)
   ) u_c (
      .clk (clk), .rst (rst), .ts_clear (1'b0),
      .in_valid (1'b0), .in_ready (in_ready_c),
      .in_x (9'd0), .in_y (9'd0), .in_pol (1'b0),
      .out_valid (out_valid_c), .out_ready (1'b0), .out_event (out_event_c),
      .ts_us (ts_c), .ts_wrap (ts_wrap_c), .drop_count (drop_c)
   );

   // ---------------- scoreboard state ----------------
   logic [26:0] exp_q[$];
   logic [7:0]  exp_ts;
   logic        exp_wrap;
   logic [15:0] exp_drop;
   logic        cur_keep;
   int          n_cmp;
   int          n_bad;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: predict the edge from the bench's own model, then check the main instance
   task automatic step();
      logic        r, clr, acc, pop;
      logic [26:0] head;
      #1;
      r   = rst;
      clr = ts_clear_a;
      acc = in_valid_a && !r && (exp_q.size() < 4);
      pop = !r && out_ready_a && (exp_q.size() != 0);
      if (pop) begin
         head = exp_q.pop_front();
         check("head_event", 64'(out_event_a), 64'(head));
      end
      if (acc) begin
         if (cur_keep) exp_q.push_back({in_x_a, in_y_a, in_pol_a, exp_ts});
         else if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
      end
      @(posedge clk);
      #1;
      if (r) begin
         exp_q.delete();
         exp_drop = '0;
         exp_ts   = '0;
         exp_wrap = 1'b0;
      end else if (clr) begin
         exp_ts   = '0;
         exp_wrap = 1'b0;
      end else begin
         exp_wrap = (exp_ts == 8'hFF);
         exp_ts   = exp_ts + 8'd1;
      end
      check("ts_us",      64'(ts_a),        64'(exp_ts));
      check("ts_wrap",    64'(ts_wrap_a),   64'(exp_wrap));
      check("out_valid",  64'(out_valid_a), 64'(exp_q.size() != 0));
      check("in_ready",   64'(in_ready_a),  64'(!rst && (exp_q.size() < 4)));
      check("drop_count", 64'(drop_a),      64'(exp_drop));
   endtask

   task automatic send(input logic [8:0] x, input logic [8:0] y, input logic pol, input logic keep);
      in_valid_a = 1'b1;
      in_x_a     = x;
      in_y_a     = y;
      in_pol_a   = pol;
      cur_keep   = keep;
      step();
      in_valid_a = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [8:0] x;
      logic [8:0] y;
      logic       pol;
      logic       keep;
   } vec_t;

   vec_t        tbl[7];
   logic [26:0] stamp_exp;

   initial begin
      // x, y, pol, kept (in range on a 346x260 sensor)
      tbl[0] = '{9'd346, 9'd0,   1'b0, 1'b0};
      tbl[1] = '{9'd0,   9'd260, 1'b1, 1'b0};
      tbl[2] = '{9'd10,  9'd10,  1'b1, 1'b1};
      tbl[3] = '{9'd0,   9'd0,   1'b0, 1'b1};
      tbl[4] = '{9'd345, 9'd259, 1'b0, 1'b1};
      tbl[5] = '{9'd511, 9'd511, 1'b1, 1'b0};
      tbl[6] = '{9'd100, 9'd200, 1'b1, 1'b1};
      stamp_exp = {9'd345, 9'd259, 1'b1, 8'd7};

      n_cmp = 0;
      n_bad = 0;
      exp_ts = '0; exp_wrap = 1'b0; exp_drop = '0; cur_keep = 1'b0;
      rst = 1'b1; ts_clear_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b0;
      in_x_a = '0; in_y_a = '0; in_pol_a = 1'b0;

      // Reset state
      repeat (3) step();
      check("rst_out_event", 64'(out_event_a), 64'd0);
      check("rst_in_ready",  64'(in_ready_a),  64'd0);
      rst = 1'b0;

      // Timestamp tick (divisor 4) and wrap (4-bit, divisor 1), idle inputs
      for (int k = 1; k <= 17; k++) begin
         step();
         check("tick_ts_b",   64'(ts_b),      64'(k / 4));
         check("tick_wrap_b", 64'(ts_wrap_b), 64'd0);
         check("wrap_ts_c",   64'(ts_c),      64'(k % 16));
         check("wrap_pulse_c", 64'(ts_wrap_c), 64'(k == 16));
      end

      // Stamp and one-cycle latency: event offered while ts_us reads 7
      ts_clear_a = 1'b1;
      step();
      ts_clear_a = 1'b0;
      repeat (7) step();
      send(9'd345, 9'd259, 1'b1, 1'b1);
      check("stamp_valid", 64'(out_valid_a), 64'd1);
      check("stamp_event", 64'(out_event_a), 64'(stamp_exp));
      out_ready_a = 1'b1;
      step();

      // Range check and drops, streaming with the consumer always ready
      for (int i = 0; i < 7; i++) send(tbl[i].x, tbl[i].y, tbl[i].pol, tbl[i].keep);
      repeat (2) step();
      check("drop_total", 64'(drop_a), 64'd3);

      // Backpressure: fill with the consumer stalled, then release
      out_ready_a = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_valid_a = 1'b1;
         in_x_a = 9'(i + 1); in_y_a = 9'(i + 2); in_pol_a = i[0]; cur_keep = 1'b1;
         step();
      end
      in_valid_a = 1'b0;
      check("bp_full_ready", 64'(in_ready_a), 64'd0);
      out_ready_a = 1'b1;
      step();
      check("bp_ready_after_pop", 64'(in_ready_a), 64'd1);
      repeat (4) step();

      // ts_clear at ts_us=50 keeps buffered events
      out_ready_a = 1'b0;
      send(9'd20, 9'd30, 1'b0, 1'b1);
      send(9'd21, 9'd31, 1'b1, 1'b1);
      for (int i = 0; i < 300 && exp_ts != 8'd50; i++) step();
      check("clear_at_50", 64'(ts_a), 64'd50);
      ts_clear_a = 1'b1;
      step();
      ts_clear_a = 1'b0;
      check("clear_ts_zero",   64'(ts_a),        64'd0);
      check("clear_keeps_fifo", 64'(out_valid_a), 64'd1);
      out_ready_a = 1'b1;
      repeat (3) step();

      // Reset with three events buffered
      out_ready_a = 1'b0;
      send(9'd1, 9'd2, 1'b1, 1'b1);
      send(9'd3, 9'd4, 1'b0, 1'b1);
      send(9'd5, 9'd6, 1'b1, 1'b1);
      send(9'd400, 9'd6, 1'b1, 1'b0);
      rst = 1'b1;
      step();
      check("rst_mid_valid", 64'(out_valid_a), 64'd0);
      check("rst_mid_drop",  64'(drop_a),      64'd0);
      check("rst_mid_event", 64'(out_event_a), 64'd0);
      rst = 1'b0;
      step();
      check("rst_release_ready", 64'(in_ready_a), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
